// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-in serial-out transmitter
//
// Takes a WIDTH-bit word through a valid/ready handshake and shifts it out one
// bit per enabled clock. Start/end-of-frame markers are aligned to the serial
// bit so the receiver can re-frame the stream. Back-to-back words are sent
// with no idle gap when a new word is offered on the last bit of the current.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   en          bit-rate strobe; state advances only on edges with en=1
//   din         parallel word
//   load_valid  din is valid
//   load_ready  transmitter can take din on this edge (combinational)
//   sout        serial data bit (registered)
//   sout_bar    complement of sout (registered)
//   sout_valid  sout carries a word bit
//   sof / eof   first / last bit of a word
//   busy        word in flight (same as sout_valid)
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_bar,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_sout_bar;
    logic             r_valid;
    logic             r_sof;
    logic             r_eof;

    logic             w_accept;
    logic             w_first_bit;
    logic [WIDTH-1:0] w_rest;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shifted;

    // Bit order is fixed at elaboration: the next bit always sits at the
    // exit end of r_shift, and shifting moves the following bit there.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_first_bit = din[WIDTH-1];
            assign w_rest      = din << 1;
            assign w_next_bit  = r_shift[WIDTH-1];
            assign w_shifted   = r_shift << 1;
        end else begin : g_lsb
            assign w_first_bit = din[0];
            assign w_rest      = din >> 1;
            assign w_next_bit  = r_shift[0];
            assign w_shifted   = r_shift >> 1;
        end
    endgenerate

    // Counter is always 0 in IDLE, so the last-bit test also covers idle.
    assign load_ready = en && ((r_state == S_IDLE) || (r_cnt == '0));
    assign w_accept   = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_sout     <= 1'b0;
            r_sout_bar <= 1'b1;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else if (en) begin
            if (w_accept) begin
                // First bit goes straight to the output on the accepting edge.
                r_state    <= S_SHIFT;
                r_shift    <= w_rest;
                r_cnt      <= LAST;
                r_sout     <= w_first_bit;
                r_sout_bar <= ~w_first_bit;
                r_valid    <= 1'b1;
                r_sof      <= 1'b1;
                r_eof      <= (WIDTH == 1);
            end else if (r_state == S_SHIFT) begin
                if (r_cnt != '0) begin
                    r_shift    <= w_shifted;
                    r_cnt      <= r_cnt - 1'b1;
                    r_sout     <= w_next_bit;
                    r_sout_bar <= ~w_next_bit;
                    r_sof      <= 1'b0;
                    r_eof      <= (r_cnt == CW'(1));
                end else begin
                    // Word done, nothing offered: sout keeps its last value.
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_sof   <= 1'b0;
                    r_eof   <= 1'b0;
                end
            end
        end
    end

    assign sout       = r_sout;
    assign sout_bar   = r_sout_bar;
    assign sout_valid = r_valid;
    assign busy       = r_valid;
    assign sof        = r_sof;
    assign eof        = r_eof;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx : self-checking bench for piso_tx
//
// Three instances share one stimulus stream: WIDTH=8 MSB-first, WIDTH=8
// LSB-first and WIDTH=1. Each is compared every cycle against a word/bit-index
// reference model of the serial stream.
// -----------------------------------------------------------------------------
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       lv  = 1'b0;

    logic [2:0] rdy, so, sob, sv, sf, ef, bz;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .din(din), .load_valid(lv),
        .load_ready(rdy[0]), .sout(so[0]), .sout_bar(sob[0]), .sout_valid(sv[0]),
        .sof(sf[0]), .eof(ef[0]), .busy(bz[0]));

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .din(din), .load_valid(lv),
        .load_ready(rdy[1]), .sout(so[1]), .sout_bar(sob[1]), .sout_valid(sv[1]),
        .sof(sf[1]), .eof(ef[1]), .busy(bz[1]));

    piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .en(en), .din(din[0:0]), .load_valid(lv),
        .load_ready(rdy[2]), .sout(so[2]), .sout_bar(sob[2]), .sout_valid(sv[2]),
        .sof(sf[2]), .eof(ef[2]), .busy(bz[2]));

    // Reference model: current word, index of the bit on the line, flags.
    int m_w   [3] = '{8, 8, 1};
    int m_msb [3] = '{1, 0, 1};
    int m_word[3];
    int m_k   [3];
    int m_v   [3];
    int m_sof [3];
    int m_eof [3];
    int m_sout[3];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int bit_at(input int i, input int k);
        int idx;
        idx = (m_msb[i] != 0) ? (m_w[i] - 1 - k) : k;
        return (m_word[i] >> idx) & 1;
    endfunction

    function automatic int m_ready(input int i);
        return (en && (m_v[i] == 0 || m_k[i] == m_w[i] - 1)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_word[i] = 0; m_k[i] = 0; m_v[i] = 0;
            m_sof[i] = 0;  m_eof[i] = 0; m_sout[i] = 0;
        end
    endtask

    // Called on an edge with the inputs that were present before it.
    task automatic model_edge();
        int r;
        if (!en) return;
        for (int i = 0; i < 3; i++) begin
            r = (m_v[i] == 0 || m_k[i] == m_w[i] - 1) ? 1 : 0;
            if (lv && r != 0) begin
                m_word[i] = int'(din);
                m_k[i] = 0; m_v[i] = 1; m_sof[i] = 1;
                m_eof[i] = (m_w[i] == 1) ? 1 : 0;
                m_sout[i] = bit_at(i, 0);
            end else if (m_v[i] != 0 && m_k[i] < m_w[i] - 1) begin
                m_k[i]++;
                m_sof[i] = 0;
                m_eof[i] = (m_k[i] == m_w[i] - 1) ? 1 : 0;
                m_sout[i] = bit_at(i, m_k[i]);
            end else if (m_v[i] != 0) begin
                m_v[i] = 0; m_sof[i] = 0; m_eof[i] = 0;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.sout%0d", tag, i),  32'(so[i]),  32'(m_sout[i]));
            chk($sformatf("%s.soutb%0d", tag, i), 32'(sob[i]), 32'(~m_sout[i] & 1));
            chk($sformatf("%s.valid%0d", tag, i), 32'(sv[i]),  32'(m_v[i]));
            chk($sformatf("%s.busy%0d", tag, i),  32'(bz[i]),  32'(m_v[i]));
            chk($sformatf("%s.sof%0d", tag, i),   32'(sf[i]),  32'(m_sof[i]));
            chk($sformatf("%s.eof%0d", tag, i),   32'(ef[i]),  32'(m_eof[i]));
        end
    endtask

    // One clock: drive at negedge, check ready before the edge, outputs after.
    task automatic cycle(input string tag, input logic e, input logic v, input logic [7:0] d);
        @(negedge clk);
        en = e; lv = v; din = d;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s.rdy%0d", tag, i), 32'(rdy[i]), 32'(m_ready(i)));
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_outs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single word, then idle to see sout hold and valid drop.
        cycle("a5", 1'b1, 1'b1, 8'hA5);
        for (int c = 0; c < 9; c++) cycle("a5", 1'b1, 1'b0, 8'h00);

        // Back-to-back with load_valid held high.
        cycle("b2b", 1'b1, 1'b1, 8'hA5);
        for (int c = 0; c < 7; c++) cycle("b2b", 1'b1, 1'b1, 8'h3C);
        cycle("b2b", 1'b1, 1'b1, 8'h3C);
        for (int c = 0; c < 9; c++) cycle("b2b", 1'b1, 1'b0, 8'h00);

        // LSB-first single-bit word (also exercises the other instances).
        cycle("lsb", 1'b1, 1'b1, 8'h01);
        for (int c = 0; c < 9; c++) cycle("lsb", 1'b1, 1'b0, 8'h00);

        // Gated strobe: load_valid held during en=0 must not be taken.
        cycle("en", 1'b1, 1'b1, 8'hF0);
        for (int c = 0; c < 24; c++)
            cycle("en", (c % 3) == 2, 1'b1, 8'h0F);
        for (int c = 0; c < 10; c++) cycle("en", 1'b1, 1'b0, 8'h00);

        // Asynchronous reset mid-word, then a clean word.
        cycle("rst", 1'b1, 1'b1, 8'hFF);
        for (int c = 0; c < 3; c++) cycle("rst", 1'b1, 1'b0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outs("arst");
        @(negedge clk);
        rst = 1'b1;
        cycle("post", 1'b1, 1'b1, 8'h81);
        for (int c = 0; c < 9; c++) cycle("post", 1'b1, 1'b0, 8'h00);

        // WIDTH=1 alternating data with load_valid held.
        cycle("w1", 1'b1, 1'b1, 8'h01);
        cycle("w1", 1'b1, 1'b1, 8'h00);
        cycle("w1", 1'b1, 1'b1, 8'h01);
        for (int c = 0; c < 9; c++) cycle("w1", 1'b1, 1'b0, 8'h00);

        // Random traffic.
        for (int c = 0; c < 400; c++)
            cycle("rnd", ($urandom % 4) != 0, ($urandom % 2) == 1, 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock on a single serial line. It drives the input end of the team's serial shift-register chains and serial links. Start-of-frame and end-of-frame markers are aligned to the serial bit so the far end can re-frame the stream.

Parameters:
WIDTH, 8, word length in bits; legal range 1..32.
MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
en  input  1  bit-rate strobe; the shift/advance happens only on edges where en=1.
din  input  WIDTH  parallel word to send.
load_valid  input  1  din is valid.
load_ready  output  1  the transmitter can take din this edge.
sout  output  1  serial data bit, registered.
sout_bar  output  1  complement of sout, registered.
sout_valid  output  1  sout carries a word bit.
sof  output  1  high with the first bit of each word.
eof  output  1  high with the last bit of each word.
busy  output  1  a word is in flight (equals sout_valid).

Behaviour:
- Reset (rst=0, async, independent of clk): shift register = 0, bit counter = 0, state = IDLE, sout = 0, sout_bar = 1, sout_valid = 0, sof = 0, eof = 0. Reset entered mid-word discards the word with no partial completion. The first word after reset release is accepted normally.
- States:
  - IDLE: sout_valid = 0.
  - SHIFT: sout_valid = 1; the counter holds the number of bits still to send after the current one (WIDTH-1 down to 0).
- load_ready (combinational) = en AND (state == IDLE OR counter == 0).
- Accept = load_valid AND load_ready, evaluated on the rising edge. On accept:
  - the first bit of din drives sout on that edge;
  - sof = 1; eof = 1 only if WIDTH = 1;
  - counter = WIDTH-1; state = SHIFT;
  - the remaining bits are captured into the shift register.
  - Latency: din to first bit on sout is 1 clock.
- In SHIFT with en=1 and counter > 0: present the next bit (order set by MSB_FIRST), decrement the counter, sof = 0, and eof = 1 when the new counter value is 0.
- In SHIFT with en=1 and counter == 0:
  - if an accept occurs, load the new word on that edge with no idle gap (back-to-back);
  - otherwise go to IDLE, sout_valid = 0, eof = 0, and sout holds its last value.
- en=0: every register holds, outputs are frozen, load_ready = 0, and no accept is possible even in IDLE.
- sout_bar always equals ~sout, including after reset.
- din and load_valid are ignored when no accept occurs. din may change freely after the accepting edge.
- A word is WIDTH enabled edges long: sout_valid stays high for exactly WIDTH en=1 edges per word.
- WIDTH = 1: every accepted word has sof = eof = 1 on its single bit, and load_ready is high every enabled cycle.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, en=1, din=8'hA5 accepted once -> sout over 8 cycles = 1,0,1,0,0,1,0,1; sof on bit 1 only; eof on bit 8 only; sout_valid low on cycle 9; sout_bar always inverted.
2. Back-to-back: 8'hA5 then 8'h3C, load_valid held high -> 16 contiguous valid bits 10100101 00111100; load_ready high only at idle and on bit-8 cycles; sof on bits 1 and 9; no gap.
3. MSB_FIRST=0, din=8'h01 -> sout = 1,0,0,0,0,0,0,0.
4. en toggled 1,0,0,1,... during 8'hF0 -> bits advance only on en=1 edges; outputs frozen otherwise; total valid en=1 edges = 8; load_valid during en=0 is not accepted.
5. rst pulled low asynchronously (between clk edges) at bit 4 of 8'hFF -> outputs go immediately to sout=0, sout_bar=1, sout_valid=0, sof=eof=0; after release, 8'h81 transmits cleanly from bit 1.
6. WIDTH=1, din alternating 1,0,1 with load_valid held -> sout=1,0,1; sof=eof=1 every cycle; load_ready continuously high.
